// File: rtl/demux_rr_arbiter_if.sv
// Handshake bundle between requesters and the round-robin demux arbiter.
// The requester side drives req/mask; the arbiter returns the decoder
// select, enable, one-hot grant and busy status.
interface demux_rr_arbiter_if;
  logic [15:0] req;
  logic [15:0] mask;
  logic [3:0]  sel;
  logic        en;
  logic [15:0] gnt;
  logic        busy;

  modport master (
    output req,
    output mask,
    input  sel,
    input  en,
    input  gnt,
    input  busy
  );

  modport slave (
    input  req,
    input  mask,
    output sel,
    output en,
    output gnt,
    output busy
  );
endinterface

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter driving a 4-to-16 decoder/demux.
// Every owner is bounded to MAX_HOLD cycles. A single GAP cycle separates
// any two grants so that the demux always breaks before it makes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; the next winner is searched every cycle
// GRANT | sel owns the channel; en=1, gnt is one-hot; hold_q counts up
// GAP   | one break-before-make cycle; sel keeps the last owner
module demux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic              clk,
  input logic              rst,
  demux_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic [15:0] gnt_q, gnt_d;

  logic [15:0] ereq;
  logic [3:0]  idx;
  logic [3:0]  win;
  logic        found;

  // Winner search: first set bit of ereq going upward from ptr+1. The last
  // step (offset 16) lands back on ptr itself, so a lone requester can win
  // again after it times out.
  always_comb begin
    ereq  = bus.req & bus.mask;
    win   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int i = 1; i <= 16; i++) begin
      idx = ptr_q + 4'(i);
      if (!found && ereq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. All outputs are computed here and
  // then registered, so req/mask never reach a port combinationally.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    en_d    = 1'b0;
    gnt_d   = 16'h0000;
    case (state_q)
      IDLE, GAP: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          ptr_d   = win;
          hold_d  = 8'd1;
          en_d    = 1'b1;
          gnt_d   = 16'h0001 << win;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // A release and a hold timeout both lead to GAP.
        if (!ereq[sel_q] || (hold_q == 8'(MAX_HOLD))) begin
          state_d = GAP;
        end else begin
          hold_d = hold_q + 8'd1;
          en_d   = 1'b1;
          gnt_d  = gnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 4'd0;
      ptr_q   <= 4'd15;
      hold_q  <= 8'd0;
      en_q    <= 1'b0;
      gnt_q   <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.en   = en_q;
  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Bench for demux_rr_arbiter: a reference model pushes the expected outputs
// for each driven cycle into a queue, which is popped and compared after the
// clock edge. Directed scenarios add checks against fixed values.
module tb_demux_rr_arbiter;
  localparam int MH = 8;

  logic clk;
  logic rst;
  demux_rr_arbiter_if bus ();

  demux_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        en;
    logic [15:0] gnt;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: 0 = IDLE, 1 = GRANT, 2 = GAP
  int          m_state;
  int          m_ptr;
  int          m_hold;
  logic [3:0]  m_sel;
  logic        m_en;
  logic [15:0] m_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [15:0] rq, input logic [15:0] mk);
    logic [15:0] e;
    int w;
    if (r) begin
      m_state = 0; m_ptr = 15; m_hold = 0;
      m_sel = 4'd0; m_en = 1'b0; m_gnt = 16'h0;
    end else begin
      e = rq & mk;
      if (m_state == 1) begin
        if (e[m_sel] == 1'b0 || m_hold == MH) begin
          m_state = 2; m_en = 1'b0; m_gnt = 16'h0;
        end else begin
          m_hold = m_hold + 1;
        end
      end else begin
        w = -1;
        for (int k = 1; k <= 16; k++)
          if (w < 0 && e[(m_ptr + k) % 16]) w = (m_ptr + k) % 16;
        if (w >= 0) begin
          m_state = 1; m_ptr = w; m_hold = 1;
          m_sel = 4'(w); m_en = 1'b1; m_gnt = 16'h0;
          m_gnt[w] = 1'b1;
        end else begin
          m_state = 0; m_en = 1'b0; m_gnt = 16'h0;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] mk);
    exp_t x;
    @(negedge clk);
    rst      = r;
    bus.req  = rq;
    bus.mask = mk;
    model_step(r, rq, mk);
    x.sel  = m_sel;
    x.en   = m_en;
    x.gnt  = m_gnt;
    x.busy = (m_state != 0);
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check("sb_sel",  32'(bus.sel),  32'(x.sel));
      check("sb_en",   32'(bus.en),   32'(x.en));
      check("sb_gnt",  32'(bus.gnt),  32'(x.gnt));
      check("sb_busy", 32'(bus.busy), 32'(x.busy));
    end
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    if (!bus.en) check("gnt_when_off", 32'(bus.gnt), 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 16'hFFFF, 16'hFFFF);
    step(1'b1, 16'h0000, 16'hFFFF);
  endtask

  logic [15:0] exp_g;
  logic [15:0] rq_r;
  logic [15:0] mk_r;

  initial begin
    rst      = 1'b1;
    bus.req  = 16'h0;
    bus.mask = 16'h0;
    m_state = 0; m_ptr = 15; m_hold = 0;
    m_sel = 4'd0; m_en = 1'b0; m_gnt = 16'h0;

    // reset values
    do_reset();
    check("rst_sel",  32'(bus.sel),  32'd0);
    check("rst_en",   32'(bus.en),   32'd0);
    check("rst_gnt",  32'(bus.gnt),  32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // first request grants one cycle later, no dead cycle after reset
    step(1'b0, 16'h0001, 16'hFFFF);
    check("first_sel",  32'(bus.sel),  32'd0);
    check("first_en",   32'(bus.en),   32'd1);
    check("first_gnt",  32'(bus.gnt),  32'h0001);
    check("first_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 16'h0000, 16'hFFFF);
    check("release_gap_gnt",  32'(bus.gnt),  32'd0);
    check("release_gap_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 16'h0000, 16'hFFFF);
    check("back_idle_busy", 32'(bus.busy), 32'd0);

    // full rotation under all requests: 8 grant cycles then one GAP
    do_reset();
    for (int k = 0; k < 160; k++) begin
      step(1'b0, 16'hFFFF, 16'hFFFF);
      exp_g = ((k % 9) < 8) ? (16'h0001 << ((k / 9) % 16)) : 16'h0000;
      check("rotate_gnt", 32'(bus.gnt), 32'(exp_g));
    end

    // owner 5 releases after 3 cycles while 9 waits
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0220, 16'hFFFF);
      check("own5_gnt", 32'(bus.gnt), 32'h0020);
    end
    step(1'b0, 16'h0200, 16'hFFFF);
    check("own5_gap_gnt", 32'(bus.gnt), 32'h0000);
    check("own5_gap_sel", 32'(bus.sel), 32'd5);
    step(1'b0, 16'h0200, 16'hFFFF);
    check("own9_gnt", 32'(bus.gnt), 32'h0200);
    check("own9_sel", 32'(bus.sel), 32'd9);

    // ptr=14: wrap search picks 0 rather than 14
    do_reset();
    step(1'b0, 16'h4000, 16'hFFFF);
    check("own14_gnt", 32'(bus.gnt), 32'h4000);
    step(1'b0, 16'h0000, 16'hFFFF);
    step(1'b0, 16'h0000, 16'hFFFF);
    check("own14_idle", 32'(bus.busy), 32'd0);
    step(1'b0, 16'h4001, 16'hFFFF);
    check("wrap_gnt", 32'(bus.gnt), 32'h0001);
    check("wrap_sel", 32'(bus.sel), 32'd0);

    // masked request is ignored; mask drop mid-grant forces GAP
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0010, 16'h0000);
      check("masked_en",   32'(bus.en),   32'd0);
      check("masked_busy", 32'(bus.busy), 32'd0);
    end
    step(1'b0, 16'h0010, 16'hFFFF);
    check("unmask_gnt", 32'(bus.gnt), 32'h0010);
    step(1'b0, 16'h0010, 16'hFFEF);
    check("maskdrop_gnt",  32'(bus.gnt),  32'h0000);
    check("maskdrop_sel",  32'(bus.sel),  32'd4);
    check("maskdrop_busy", 32'(bus.busy), 32'd1);
    step(1'b0, 16'h0010, 16'hFFEF);
    check("maskdrop_idle", 32'(bus.busy), 32'd0);

    // sole requester times out and is re-granted after one GAP
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 16'h0008, 16'hFFFF);
      exp_g = (k == 8) ? 16'h0000 : 16'h0008;
      check("sole_gnt", 32'(bus.gnt), 32'(exp_g));
      check("sole_sel", 32'(bus.sel), 32'd3);
    end

    // reset mid-grant, then first grant goes to index 0
    do_reset();
    step(1'b0, 16'h0080, 16'hFFFF);
    check("own7_gnt", 32'(bus.gnt), 32'h0080);
    step(1'b1, 16'hFFFF, 16'hFFFF);
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_en",  32'(bus.en),  32'd0);
    check("midrst_sel", 32'(bus.sel), 32'd0);
    step(1'b0, 16'hFFFF, 16'hFFFF);
    check("postrst_gnt", 32'(bus.gnt), 32'h0001);

    // random traffic checked against the model
    for (int k = 0; k < 400; k++) begin
      rq_r = 16'($urandom) & 16'($urandom);
      mk_r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      step(($urandom_range(0, 59) == 0), rq_r, mk_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
